// File: rtl/bsg_dff_en_rr_share_pkg.sv
// Shared types and helpers for the round-robin shared enable-register stage.
// Optional burst locking is enabled with BSG_DFF_EN_RR_SHARE_LOCK_EN.
package bsg_dff_en_rr_share_pkg;

   localparam int max_req_lp = 16;

   // Pointer/tag index wide enough for the largest legal requester count.
   typedef logic [$clog2(max_req_lp)-1:0] rr_idx_t;

   function automatic int tag_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/bsg_dff_en.sv
// Enable flop: captures data_i on rising edges where en_i is high.
module bsg_dff_en #(
   parameter int width_p = 16
) (
   input  logic               clk_i,
   input  logic               en_i,
   input  logic [width_p-1:0] data_i,
   output logic [width_p-1:0] data_o
);

   // NOTE: datapath register has no reset; its contents are qualified by a separate valid flop.
   always_ff @(posedge clk_i) begin
      if (en_i)
         data_o <= data_i;
   end

endmodule

// File: rtl/bsg_dff_en_rr_share_arb.sv
// Rotating-priority arbiter with its priority pointer; optional lock holds the last winner.
module bsg_dff_en_rr_share_arb
   import bsg_dff_en_rr_share_pkg::*;
#(
   parameter int num_req_p    = 4,
   parameter int tag_width_lp = tag_width(num_req_p)
) (
   input  logic                    clk_i,
   input  logic                    reset_i,
   input  logic [num_req_p-1:0]    reqs,
   input  logic                    ready,
   input  logic                    lock,
   input  logic [tag_width_lp-1:0] lock_idx,
   output logic [num_req_p-1:0]    grant,
   output logic [tag_width_lp-1:0] idx
);

   rr_idx_t ptr_r;
   logic    found;
   logic    locked_pick;
   int      cand;
   int      ptr_next;

   // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      found       = 1'b0;
      locked_pick = 1'b0;
      idx         = '0;
      cand        = 0;
      for (int i = 0; i < num_req_p; i++) begin
         cand = int'(ptr_r) + i;
         if (cand >= num_req_p)
            cand = cand - num_req_p;
         if (!found && reqs[cand]) begin
            found = 1'b1;
            idx   = tag_width_lp'(cand);
         end
      end
      // A locked burst overrides the rotation only while its owner keeps requesting.
      if (lock && (int'(lock_idx) < num_req_p) && reqs[lock_idx]) begin
         found       = 1'b1;
         locked_pick = 1'b1;
         idx         = lock_idx;
      end
      grant = '0;
      if (found && ready && !reset_i)
         grant = num_req_p'(1) << idx;
   end

   always_comb begin
      ptr_next = int'(idx) + 1;
      if (ptr_next >= num_req_p)
         ptr_next = 0;
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk_i) begin
      if (reset_i)
         ptr_r <= '0;
      else if ((|grant) && !locked_pick)
         ptr_r <= rr_idx_t'(ptr_next);
   end

endmodule

// File: rtl/bsg_dff_en_rr_share.sv
// Round-robin shares one bsg_dff_en stage between num_req_p requesters.
// Define BSG_DFF_EN_RR_SHARE_LOCK_EN to add lock_i for multi-word bursts.
module bsg_dff_en_rr_share
   import bsg_dff_en_rr_share_pkg::*;
#(
   parameter  int width_p      = 16,
   parameter  int num_req_p    = 4,
   localparam int tag_width_lp = tag_width(num_req_p)
) (
   input  logic                           clk_i,
   input  logic                           reset_i,
   input  logic [num_req_p-1:0]           v_i,
   input  logic [num_req_p*width_p-1:0]   data_i,
   output logic [num_req_p-1:0]           yumi_o,
`ifdef BSG_DFF_EN_RR_SHARE_LOCK_EN
   input  logic                           lock_i,
`endif
   output logic                           v_o,
   output logic [width_p-1:0]             data_o,
   output logic [tag_width_lp-1:0]        tag_o,
   input  logic                           yumi_i
);

   logic                    drain;
   logic                    ready;
   logic                    en;
   logic                    lock;
   logic [tag_width_lp-1:0] win_idx;
   logic [width_p-1:0]      win_data;

`ifdef BSG_DFF_EN_RR_SHARE_LOCK_EN
   assign lock = lock_i;
`else
   assign lock = 1'b0;
`endif

   // A drain request with nothing held is ignored.
   assign drain = yumi_i & v_o;
   assign ready = ~v_o | drain;
   assign en    = |yumi_o;

   bsg_dff_en_rr_share_arb #(
      .num_req_p    (num_req_p),
      .tag_width_lp (tag_width_lp)
   ) arb (
      .clk_i    (clk_i),
      .reset_i  (reset_i),
      .reqs     (v_i),
      .ready    (ready),
      .lock     (lock),
      .lock_idx (tag_o),
      .grant    (yumi_o),
      .idx      (win_idx)
   );

   always_comb begin
      win_data = '0;
      for (int k = 0; k < num_req_p; k++) begin
         if (yumi_o[k])
            win_data = win_data | data_i[k*width_p +: width_p];
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         v_o   <= 1'b0;
         tag_o <= '0;
      end else if (en) begin
         v_o   <= 1'b1;
         tag_o <= win_idx;
      end else if (drain) begin
         v_o   <= 1'b0;
      end
   end

   bsg_dff_en #(
      .width_p (width_p)
   ) data_reg (
      .clk_i  (clk_i),
      .en_i   (en),
      .data_i (win_data),
      .data_o (data_o)
   );

`ifndef SYNTHESIS
   yumi_without_valid: assert property (@(posedge clk_i) disable iff (reset_i) !(yumi_i && !v_o));
`endif

endmodule

// File: tb/tb_bsg_dff_en_rr_share.sv
// Directed self-checking bench for bsg_dff_en_rr_share (width 16, four requesters).
module tb_bsg_dff_en_rr_share;

   localparam int width_p   = 16;
   localparam int num_req_p = 4;

   logic                         clk_i = 1'b0;
   logic                         reset_i;
   logic [num_req_p-1:0]         v_i;
   logic [num_req_p*width_p-1:0] data_i;
   logic [num_req_p-1:0]         yumi_o;
   logic                         v_o;
   logic [width_p-1:0]           data_o;
   logic [1:0]                   tag_o;
   logic                         yumi_i;
`ifdef BSG_DFF_EN_RR_SHARE_LOCK_EN
   logic                         lock_i;
`endif

   int errors = 0;
   int checks = 0;

   bsg_dff_en_rr_share #(
      .width_p   (width_p),
      .num_req_p (num_req_p)
   ) dut (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .v_i     (v_i),
      .data_i  (data_i),
      .yumi_o  (yumi_o),
`ifdef BSG_DFF_EN_RR_SHARE_LOCK_EN
      .lock_i  (lock_i),
`endif
      .v_o     (v_o),
      .data_o  (data_o),
      .tag_o   (tag_o),
      .yumi_i  (yumi_i)
   );

   always #5 clk_i = ~clk_i;

   initial begin
      #200000;
      $display("FAIL timeout: simulation time limit reached");
      $fatal(1, "time limit");
   end

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic test_reset();
      reset_i = 1'b1;
      v_i     = 4'b1111;
      yumi_i  = 1'b0;
      for (int c = 0; c < 2; c++) begin
         tick();
         checks++;
         if (yumi_o !== 4'b0000) begin
            errors++;
            $display("FAIL reset_yumi cycle %0d: got %b expected 0000", c, yumi_o);
         end
      end
      checks++;
      if ({v_o, tag_o} !== 3'b000) begin
         errors++;
         $display("FAIL reset_state: got v_o=%b tag_o=%0d expected v_o=0 tag_o=0", v_o, tag_o);
      end
      reset_i = 1'b0;
      #1;
      checks++;
      if (yumi_o !== 4'b0001) begin
         errors++;
         $display("FAIL first_grant: got %b expected 0001", yumi_o);
      end
      tick();
      checks++;
      if ({v_o, tag_o, data_o} !== {1'b1, 2'd0, 16'hA000}) begin
         errors++;
         $display("FAIL first_load: got v=%b tag=%0d data=%h expected v=1 tag=0 data=a000", v_o, tag_o, data_o);
      end
      checks++;
      if (yumi_o !== 4'b0000) begin
         errors++;
         $display("FAIL full_no_grant: got %b expected 0000", yumi_o);
      end
   endtask

   // Pointer sits at 1 with tag 0 held; pass-through must walk 1,2,3,0.
   task automatic test_rotation();
      logic [3:0]  exp_grant [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
      logic [1:0]  exp_tag   [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
      logic [15:0] exp_data  [4] = '{16'hA001, 16'hA002, 16'hA003, 16'hA000};
      v_i    = 4'b1111;
      yumi_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         checks++;
         if (yumi_o !== exp_grant[i]) begin
            errors++;
            $display("FAIL rotation_grant %0d: got %b expected %b", i, yumi_o, exp_grant[i]);
         end
         tick();
         checks++;
         if ({v_o, tag_o, data_o} !== {1'b1, exp_tag[i], exp_data[i]}) begin
            errors++;
            $display("FAIL rotation_out %0d: got v=%b tag=%0d data=%h expected tag=%0d data=%h",
                     i, v_o, tag_o, data_o, exp_tag[i], exp_data[i]);
         end
      end
   endtask

   task automatic test_backpressure();
      yumi_i = 1'b0;
      v_i    = 4'b0110;
      for (int i = 0; i < 5; i++) begin
         #1;
         checks++;
         if (yumi_o !== 4'b0000) begin
            errors++;
            $display("FAIL stall_grant %0d: got %b expected 0000", i, yumi_o);
         end
         tick();
         checks++;
         if ({v_o, tag_o, data_o} !== {1'b1, 2'd0, 16'hA000}) begin
            errors++;
            $display("FAIL stall_hold %0d: got v=%b tag=%0d data=%h expected v=1 tag=0 data=a000",
                     i, v_o, tag_o, data_o);
         end
      end
      yumi_i = 1'b1;
      #1;
      checks++;
      if (yumi_o !== 4'b0010) begin
         errors++;
         $display("FAIL release_grant1: got %b expected 0010", yumi_o);
      end
      tick();
      checks++;
      if ({tag_o, data_o} !== {2'd1, 16'hA001}) begin
         errors++;
         $display("FAIL release_load1: got tag=%0d data=%h expected tag=1 data=a001", tag_o, data_o);
      end
      checks++;
      if (yumi_o !== 4'b0100) begin
         errors++;
         $display("FAIL release_grant2: got %b expected 0100", yumi_o);
      end
      tick();
      checks++;
      if ({tag_o, data_o} !== {2'd2, 16'hA002}) begin
         errors++;
         $display("FAIL release_load2: got tag=%0d data=%h expected tag=2 data=a002", tag_o, data_o);
      end
   endtask

   // Pointer is 3 after the grant to 2; requesters 0 and 1 must be served in that order.
   task automatic test_wrap();
      v_i = 4'b0011;
      #1;
      checks++;
      if (yumi_o !== 4'b0001) begin
         errors++;
         $display("FAIL wrap_grant0: got %b expected 0001", yumi_o);
      end
      tick();
      checks++;
      if ({tag_o, data_o} !== {2'd0, 16'hA000}) begin
         errors++;
         $display("FAIL wrap_load0: got tag=%0d data=%h expected tag=0 data=a000", tag_o, data_o);
      end
      checks++;
      if (yumi_o !== 4'b0010) begin
         errors++;
         $display("FAIL wrap_grant1: got %b expected 0010", yumi_o);
      end
      tick();
      checks++;
      if ({tag_o, data_o} !== {2'd1, 16'hA001}) begin
         errors++;
         $display("FAIL wrap_load1: got tag=%0d data=%h expected tag=1 data=a001", tag_o, data_o);
      end
   endtask

   task automatic test_drain();
      v_i = 4'b0000;
      #1;
      checks++;
      if (yumi_o !== 4'b0000) begin
         errors++;
         $display("FAIL drain_grant: got %b expected 0000", yumi_o);
      end
      tick();
      yumi_i = 1'b0;
      checks++;
      if ({v_o, tag_o, data_o} !== {1'b0, 2'd1, 16'hA001}) begin
         errors++;
         $display("FAIL drain_state: got v=%b tag=%0d data=%h expected v=0 tag=1 data=a001", v_o, tag_o, data_o);
      end
      // Pointer must still be 2 after the grant-free drain.
      v_i = 4'b1111;
      #1;
      checks++;
      if (yumi_o !== 4'b0100) begin
         errors++;
         $display("FAIL drain_ptr: got %b expected 0100", yumi_o);
      end
      tick();
      checks++;
      if ({v_o, tag_o, data_o} !== {1'b1, 2'd2, 16'hA002}) begin
         errors++;
         $display("FAIL refill: got v=%b tag=%0d data=%h expected v=1 tag=2 data=a002", v_o, tag_o, data_o);
      end
   endtask

   task automatic test_mid_reset();
      reset_i = 1'b1;
      tick();
      reset_i = 1'b0;
      checks++;
      if ({v_o, tag_o} !== 3'b000) begin
         errors++;
         $display("FAIL midreset_state: got v=%b tag=%0d expected v=0 tag=0", v_o, tag_o);
      end
      #1;
      checks++;
      if (yumi_o !== 4'b0001) begin
         errors++;
         $display("FAIL midreset_ptr: got %b expected 0001", yumi_o);
      end
      tick();
      checks++;
      if ({v_o, tag_o, data_o} !== {1'b1, 2'd0, 16'hA000}) begin
         errors++;
         $display("FAIL midreset_load: got v=%b tag=%0d data=%h expected v=1 tag=0 data=a000", v_o, tag_o, data_o);
      end
   endtask

`ifdef BSG_DFF_EN_RR_SHARE_LOCK_EN
   task automatic test_lock();
      yumi_i = 1'b1;
      v_i    = 4'b0100;
      lock_i = 1'b0;
      tick();
      checks++;
      if (tag_o !== 2'd2) begin
         errors++;
         $display("FAIL lock_setup: got tag=%0d expected 2", tag_o);
      end
      lock_i = 1'b1;
      v_i    = 4'b1111;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++;
         if (yumi_o !== 4'b0100) begin
            errors++;
            $display("FAIL lock_grant %0d: got %b expected 0100", i, yumi_o);
         end
         tick();
         checks++;
         if ({tag_o, data_o} !== {2'd2, 16'hA002}) begin
            errors++;
            $display("FAIL lock_hold %0d: got tag=%0d data=%h expected tag=2 data=a002", i, tag_o, data_o);
         end
      end
      lock_i = 1'b0;
      tick();
      checks++;
      if (tag_o !== 2'd3) begin
         errors++;
         $display("FAIL unlock: got tag=%0d expected 3", tag_o);
      end
      // Winner 3 stops requesting: rotation resumes from pointer 0 despite the lock.
      lock_i = 1'b1;
      v_i    = 4'b0111;
      tick();
      checks++;
      if (tag_o !== 2'd0) begin
         errors++;
         $display("FAIL lock_owner_gone: got tag=%0d expected 0", tag_o);
      end
      lock_i = 1'b0;
   endtask
`endif

   initial begin
      for (int k = 0; k < num_req_p; k++)
         data_i[k*width_p +: width_p] = 16'hA000 + 16'(k);
      reset_i = 1'b1;
      v_i     = '0;
      yumi_i  = 1'b0;
`ifdef BSG_DFF_EN_RR_SHARE_LOCK_EN
      lock_i  = 1'b0;
`endif
      test_reset();
      test_rotation();
      test_backpressure();
      test_wrap();
      test_drain();
      test_mid_reset();
`ifdef BSG_DFF_EN_RR_SHARE_LOCK_EN
      test_lock();
`endif
      v_i    = '0;
      yumi_i = 1'b0;
      tick();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
